// File: rtl/ping_pong_sample_buffer.sv
// Ping-pong sample buffer: fills one bank with a fixed-length frame while the
// other bank is streamed out. Both bank words at the read address are
// presented, together with the read-bank select, for a downstream 2:1 MUX.
module ping_pong_sample_buffer #(
  parameter int BITS   = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  output logic [BITS-1:0] bank_a_data,
  output logic [BITS-1:0] bank_b_data,
  output logic            bank_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [7:0]      frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Sample storage; contents deliberately carry no reset.
  logic [BITS-1:0]   bank_a_r [DEPTH];
  logic [BITS-1:0]   bank_b_r [DEPTH];

  logic [1:0]        full_r;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [7:0]        frame_cnt_r;

  logic              in_ready_s;
  logic              out_valid_s;
  logic              wr_fire_s;
  logic              rd_fire_s;
  logic              wr_done_s;
  logic              rd_done_s;
  logic [1:0]        full_nxt_s;

  // Handshake decode; a bank is writable only when empty, readable only when full.
  always_comb begin
    in_ready_s  = ~full_r[wr_bank_r];
    out_valid_s = full_r[rd_bank_r];
    wr_fire_s   = in_valid && in_ready_s;
    rd_fire_s   = out_valid_s && out_ready;
    wr_done_s   = wr_fire_s && (wr_addr_r == LAST_ADDR);
    rd_done_s   = rd_fire_s && (rd_addr_r == LAST_ADDR);
  end

  // Bank full flags; a completing write and a completing read always hit different banks.
  always_comb begin
    full_nxt_s = full_r;
    if (wr_done_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (rd_done_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
    end
  end

  // Output drive straight from state so the MUX sees the read word in the same cycle.
  always_comb begin
    in_ready    = in_ready_s;
    out_valid   = out_valid_s;
    bank_sel    = rd_bank_r;
    out_last    = out_valid_s && (rd_addr_r == LAST_ADDR);
    bank_a_data = bank_a_r[rd_addr_r];
    bank_b_data = bank_b_r[rd_addr_r];
    frame_cnt   = frame_cnt_r;
  end

  // Control state: async reset and flush clear everything except bank contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      rd_addr_r   <= {ADDR_W{1'b0}};
      frame_cnt_r <= 8'd0;
    end else if (flush) begin
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      rd_addr_r   <= {ADDR_W{1'b0}};
      frame_cnt_r <= 8'd0;
    end else begin
      full_r <= full_nxt_s;
      if (wr_fire_s) begin
        if (wr_done_s) begin
          wr_addr_r <= {ADDR_W{1'b0}};
          wr_bank_r <= ~wr_bank_r;
        end else begin
          wr_addr_r <= wr_addr_r + ADDR_W'(1);
          wr_bank_r <= wr_bank_r;
        end
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_bank_r <= wr_bank_r;
      end
      if (rd_fire_s) begin
        if (rd_done_s) begin
          rd_addr_r   <= {ADDR_W{1'b0}};
          rd_bank_r   <= ~rd_bank_r;
          frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
          rd_addr_r   <= rd_addr_r + ADDR_W'(1);
          rd_bank_r   <= rd_bank_r;
          frame_cnt_r <= frame_cnt_r;
        end
      end else begin
        rd_addr_r   <= rd_addr_r;
        rd_bank_r   <= rd_bank_r;
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // Sample capture into the bank currently being filled; flush suppresses the write.
  always_ff @(posedge clk) begin
    if (wr_fire_s && !flush) begin
      if (wr_bank_r) begin
        bank_b_r[wr_addr_r] <= in_data;
      end else begin
        bank_a_r[wr_addr_r] <= in_data;
      end
    end
  end

endmodule

// File: doc/ping_pong_sample_buffer.md
Name: ping_pong_sample_buffer

Overview:
- Double-buffered (ping-pong) sample store for the CWT preprocessing chain. Sits directly upstream of the 2:1 selection MUX.
- Captures fixed-length frames of input samples into bank A or bank B while the other bank is streamed out.
- Presents both bank read words plus the select line. The downstream MUX forwards the active bank as the frame sample stream.

Parameters:
- BITS, 16, sample width; matches the MUX data width.
- DEPTH, 64, samples per frame/bank; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address/counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all control state; same effect as reset, except bank contents are not cleared.
- in_valid  input  1  in_data holds a sample.
- in_data  input  BITS  input sample.
- in_ready  output  1  buffer can accept a sample this cycle.
- bank_a_data  output  BITS  bank A word at rd_addr; drives MUX in_1.
- bank_b_data  output  BITS  bank B word at rd_addr; drives MUX in_2.
- bank_sel  output  1  read bank (0=A, 1=B); drives MUX selection_line.
- out_valid  output  1  the selected bank word is a valid frame sample.
- out_ready  input  1  consumer accepts the current sample.
- out_last  output  1  the current sample is the final sample (index DEPTH-1) of its frame.
- frame_cnt  output  8  frames fully read out; wraps 255->0.

Behaviour:
- Internal state: two register-array banks [DEPTH][BITS]; full[1:0]; wr_bank; rd_bank; wr_addr; rd_addr; frame_cnt.
- Reset (rst_n=0, asynchronous): full=00, wr_bank=0, rd_bank=0, wr_addr=0, rd_addr=0, frame_cnt=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_last=0, bank_sel=0.
  - Bank contents are not reset, so bank_*_data are undefined until written; the consumer ignores them while out_valid=0.
- flush=1 at an edge: the same state values as reset are loaded. flush has priority over any write or read in that cycle.
- Combinational outputs:
  - in_ready = !full[wr_bank].
  - out_valid = full[rd_bank].
  - bank_sel = rd_bank.
  - out_last = out_valid && (rd_addr == DEPTH-1).
  - bank_a_data = bankA[rd_addr]; bank_b_data = bankB[rd_addr].
- Write (in_valid && in_ready):
  - bank[wr_bank][wr_addr] <= in_data; wr_addr increments.
  - At wr_addr == DEPTH-1: full[wr_bank] <= 1, wr_bank toggles, and wr_addr wraps to 0.
- Read (out_valid && out_ready):
  - rd_addr increments.
  - At rd_addr == DEPTH-1: full[rd_bank] <= 0, rd_bank toggles, rd_addr wraps to 0, frame_cnt increments.
- Latency:
  - A bank becomes readable one cycle after the edge that wrote its last sample, when out_valid rises.
  - Streaming is one sample per cycle when out_ready is held high.
- Simultaneous write-complete and read-complete in the same cycle act on different banks and both take effect.
  - The same bank cannot be both written and read: a write needs !full and a read needs full.
- Both banks full: in_ready=0 and input samples are held off, never dropped. in_ready returns the cycle after the reading bank's last sample is accepted.
- Read and write addresses are independent. A partially filled write bank is never visible to the read side.
- No overflow or underflow states exist; the handshakes fully prevent them.

Test Plan:
- Fill with DEPTH=64: after reset, write 0..63 back-to-back with out_ready=0.
  - out_valid=1 the cycle after the 64th write, with bank_sel=0 and in_ready=1 (bank B free).
  - Then raise out_ready: the MUX output reads 0..63 on consecutive cycles, out_last=1 only on 63, and frame_cnt=1 afterwards.
- Backpressure: write 128 samples with out_ready=0.
  - in_ready drops after sample 127; a 129th in_valid is not accepted.
  - Reading one full frame restores in_ready exactly one cycle after the out_last handshake.
- Overlap: stream continuously at in_valid=out_ready=1 for 4 frames.
  - bank_sel alternates 0,1,0,1; output equals input delayed by one frame; frame_cnt=4; no bubbles after the first frame.
- Random stalls: drive random in_valid and out_ready for 1000 cycles.
  - Output sequence matches input order exactly; out_last lands every 64th accepted sample.
- Flush mid-frame: assert flush after 30 writes into bank B while bank A is half read.
  - Next cycle: out_valid=0, in_ready=1, bank_sel=0.
  - A fresh 64-sample frame then reads out from bank A starting at index 0.
- Async reset mid-stream: pulse rst_n low between clock edges.
  - Outputs go to reset values immediately, without a clock edge, and operation resumes cleanly after release.
